// File: rtl/dense_transpose_mac_pkg.sv
// Shared types and product-slice helpers for the transpose dense MAC.
// The slice bounds follow the fixed-point format: keep bits [WIDTH+NFRAC-1:NFRAC] of the product.
package dense_transpose_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 17;
    localparam int NFRAC_DEF = 10;
    localparam int TOP       = WIDTH_DEF + NFRAC_DEF - 1;
    localparam int BOTTOM    = NFRAC_DEF;

    function automatic int prod_top(input int width, input int nfrac);
        return width + nfrac - 1;
    endfunction

    function automatic int prod_bottom(input int nfrac);
        return nfrac;
    endfunction

    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/dense_transpose_mac_mult.sv
// Signed fixed-point multiply, truncated back to WIDTH bits (no rounding, no saturation).
// Purely combinational; no flow control.
module fx_mult
    import dense_transpose_mac_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int NFRAC = 10
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);

    localparam int P_BOT = prod_bottom(NFRAC);

    logic signed [2*WIDTH-1:0] prod_full;

    // Arithmetic shift then narrowing keeps exactly bits [WIDTH+NFRAC-1:NFRAC].
    always_comb begin
        prod_full = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        p         = WIDTH'(prod_full >>> P_BOT);
    end

endmodule

// File: rtl/dense_transpose_mac.sv
// Transpose dense layer x = b + W^T-style sum of trunc(y[j]*W[i][j]), one MAC per clock.
// Latency INPUT_SIZE*OUTPUT_SIZE cycles; result held in DONE until out_ready, input blocked meanwhile.
module dense_transpose_mac
    import dense_transpose_mac_pkg::*;
#(
    parameter int WIDTH       = 17,
    parameter int NFRAC       = 10,
    parameter int INPUT_SIZE  = 32,
    parameter int OUTPUT_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data  [0:OUTPUT_SIZE-1],
    input  logic signed [WIDTH-1:0] weights  [0:INPUT_SIZE*OUTPUT_SIZE-1],
    input  logic signed [WIDTH-1:0] bias     [0:INPUT_SIZE-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data [0:INPUT_SIZE-1]
);

    localparam int IW = cnt_width(INPUT_SIZE);
    localparam int JW = cnt_width(OUTPUT_SIZE);
    localparam int WW = cnt_width(INPUT_SIZE * OUTPUT_SIZE);
    localparam logic [IW-1:0] I_LAST = IW'(INPUT_SIZE - 1);
    localparam logic [JW-1:0] J_LAST = JW'(OUTPUT_SIZE - 1);

    state_t                  state_q, state_d;
    logic [IW-1:0]           i_q, i_d;
    logic [JW-1:0]           j_q, j_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] y_q   [0:OUTPUT_SIZE-1];
    logic signed [WIDTH-1:0] y_d   [0:OUTPUT_SIZE-1];
    logic signed [WIDTH-1:0] out_q [0:INPUT_SIZE-1];
    logic signed [WIDTH-1:0] out_d [0:INPUT_SIZE-1];

    logic [WW-1:0]           w_idx;
    logic signed [WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] sum;

    always_comb begin
        w_idx = WW'(int'(i_q) * OUTPUT_SIZE + int'(j_q));
    end

    fx_mult #(
        .WIDTH (WIDTH),
        .NFRAC (NFRAC)
    ) u_mult (
        .a (y_q[j_q]),
        .b (weights[w_idx]),
        .p (prod)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        y_d     = y_q;
        out_d   = out_q;
        sum     = acc_q + prod;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y_d     = in_data;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (j_q == J_LAST) begin
                    // Row complete: fold in the bias and retire this output element.
                    out_d[i_q] = sum + bias[i_q];
                    acc_d      = '0;
                    j_d        = '0;
                    if (i_q == I_LAST) begin
                        i_d     = '0;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    acc_d = sum;
                    j_d   = j_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            y_q     <= '{default: '0};
            out_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = out_q;
    end

endmodule

// File: tb/tb_dense_transpose_mac.sv
// Directed bench for dense_transpose_mac: 3x2 main instance plus a 1x2 fractional instance.
module tb_dense_transpose_mac;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              in_valid, in_ready, out_valid, out_ready;
    logic signed [7:0] in_data  [0:1];
    logic signed [7:0] weights  [0:5];
    logic signed [7:0] bias     [0:2];
    logic signed [7:0] out_data [0:2];

    logic              in_valid_s, in_ready_s, out_valid_s, out_ready_s;
    logic signed [7:0] in_data_s  [0:1];
    logic signed [7:0] weights_s  [0:1];
    logic signed [7:0] bias_s     [0:0];
    logic signed [7:0] out_data_s [0:0];

    int checks = 0;
    int errors = 0;

    dense_transpose_mac #(
        .WIDTH(8), .NFRAC(0), .INPUT_SIZE(3), .OUTPUT_SIZE(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .weights   (weights),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    dense_transpose_mac #(
        .WIDTH(8), .NFRAC(4), .INPUT_SIZE(1), .OUTPUT_SIZE(2)
    ) dut_s (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .in_data   (in_data_s),
        .weights   (weights_s),
        .bias      (bias_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .out_data  (out_data_s)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_w_seq();
        for (int k = 0; k < 6; k++) weights[k] = 8'(k + 1);
    endtask

    // Drive one vector, measure latency, check result, optionally stall in DONE.
    task automatic run_vec(input int y0, input int y1, input int b0, input int b1, input int b2,
                           input int e0, input int e1, input int e2, input int hold,
                           input string tag);
        int cnt;
        in_data[0] = y0[7:0];
        in_data[1] = y1[7:0];
        bias[0]    = b0[7:0];
        bias[1]    = b1[7:0];
        bias[2]    = b2[7:0];
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_lat"}, cnt, 6);
        chk({tag, "_x0"}, int'(out_data[0]), e0);
        chk({tag, "_x1"}, int'(out_data[1]), e1);
        chk({tag, "_x2"}, int'(out_data[2]), e2);
        chk({tag, "_rdy_done"}, int'(in_ready), 0);
        if (hold > 0) begin
            in_data[0] = 8'sd7;
            in_data[1] = 8'sd7;
            in_valid   = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_vld"}, int'(out_valid), 1);
                chk({tag, "_hold_rdy"}, int'(in_ready), 0);
                chk({tag, "_hold_x0"}, int'(out_data[0]), e0);
                chk({tag, "_hold_x2"}, int'(out_data[2]), e2);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_rdy_idle"}, int'(in_ready), 1);
        chk({tag, "_vld_idle"}, int'(out_valid), 0);
        in_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_valid_s  = 1'b0;
        out_ready_s = 1'b0;
        in_data     = '{default: '0};
        bias        = '{default: '0};
        in_data_s   = '{default: '0};
        weights_s   = '{default: '0};
        bias_s      = '{default: '0};
        set_w_seq();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", int'(in_ready), 1);
        chk("rst_vld", int'(out_valid), 0);
        chk("rst_x0", int'(out_data[0]), 0);
        chk("rst_x2", int'(out_data[2]), 0);
        reset = 1'b0;

        run_vec(1, -1, 0, 0, 0, -1, -1, -1, 0, "basic");
        run_vec(1, -1, 10, 0, -5, 9, -1, -6, 5, "bias_hold");

        for (int k = 0; k < 6; k++) weights[k] = 8'sd1;
        run_vec(100, 100, 0, 0, 0, -56, -56, -56, 0, "wrap");
        set_w_seq();

        // Abort a vector mid-accumulation; earlier result {-56,...} must be cleared.
        in_data[0] = 8'sd1;
        in_data[1] = -8'sd1;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_vld", int'(out_valid), 0);
        chk("mid_rst_rdy", int'(in_ready), 1);
        chk("mid_rst_x0", int'(out_data[0]), 0);
        chk("mid_rst_x1", int'(out_data[1]), 0);
        chk("mid_rst_x2", int'(out_data[2]), 0);
        #1;
        reset = 1'b0;
        run_vec(2, 3, 0, 0, 0, 8, 18, 28, 0, "post_rst");

        in_data_s[0] = 8'sh18;
        in_data_s[1] = 8'sh00;
        weights_s[0] = 8'sh20;
        weights_s[1] = 8'sh7F;
        bias_s[0]    = 8'sh00;
        in_valid_s   = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        cnt = 0;
        while (!out_valid_s && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("frac_lat", cnt, 2);
        chk("frac_x0", int'(out_data_s[0]), 48);
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        out_ready_s = 1'b0;
        chk("frac_rdy_idle", int'(in_ready_s), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
